// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Program counter and instruction fetch unit that sits in front of the 9-bit
// control decoder. It drives the instruction ROM address. It forwards the
// fetched word to the decoder. It picks the next PC from the decoder's
// Branch/Halt strobes and the ALU branch condition. Branch targets come from a
// programmable 16-entry LUT that is indexed by the low operand bits of the
// instruction.
//
// Optional build macro:
//   FETCH_PERF_EN - adds saturating cycle/instruction counters. When the macro
//                   is undefined, CycleCount and InstrCount are tied to 0.
//
// Ports:
//   Clk         in   rising-edge clock
//   Reset       in   asynchronous, active-low reset
//   Start       in   one-cycle pulse, begin (or restart) execution at StartAddr
//   StartAddr   in   first fetch address
//   Stall       in   freeze the PC this cycle (Branch/Halt/Start ignored)
//   ProgCtr     out  ROM read address
//   InstrIn     in   ROM data, combinational read of ProgCtr
//   Instr       out  instruction to decoder (0 when not running)
//   InstrValid  out  Instr is live this cycle
//   Branch      in   decoder branch strobe
//   Halt        in   decoder halt strobe
//   Taken       in   ALU branch condition
//   LutWe       in   branch-target LUT write enable
//   LutAddr     in   LUT write index
//   LutData     in   LUT write data (absolute target address)
//   Done        out  high while halted
//   CycleCount  out  RUN cycles since the last accepted Start
//   InstrCount  out  unstalled RUN cycles since the last accepted Start
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int PCW  = 10,
  parameter int IW   = 9,
  parameter int LUTD = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PCW-1:0]  StartAddr,
  input  logic            Stall,
  output logic [PCW-1:0]  ProgCtr,
  input  logic [IW-1:0]   InstrIn,
  output logic [IW-1:0]   Instr,
  output logic            InstrValid,
  input  logic            Branch,
  input  logic            Halt,
  input  logic            Taken,
  input  logic            LutWe,
  input  logic [3:0]      LutAddr,
  input  logic [PCW-1:0]  LutData,
  output logic            Done,
  output logic [15:0]     CycleCount,
  output logic [15:0]     InstrCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [PCW-1:0] PC_ONE = PCW'(1);

  state_t          state;
  state_t          state_next;
  logic [PCW-1:0]  pc;
  logic [PCW-1:0]  pc_next;
  logic            start_accept;
  logic [PCW-1:0]  lut [LUTD];
  logic [PCW-1:0]  lut_target;

  // The LUT is read combinationally, so a write in the same cycle as a
  // taken branch to that index still yields the old target for the branch.
  assign lut_target = lut[InstrIn[3:0]];

  // State and PC register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next-state and next-PC selection. While running, Stall has top
  // priority and masks Start as well as the decoder strobes. A Start
  // restart beats Halt and Branch.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    start_accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          state_next   = RUN;
          pc_next      = StartAddr;
          start_accept = 1'b1;
        end
      end
      RUN: begin
        if (!Stall) begin
          if (Start) begin
            pc_next      = StartAddr;
            start_accept = 1'b1;
          end else if (Halt) begin
            state_next = HALTED;
          end else if (Branch && Taken) begin
            pc_next = lut_target;
          end else begin
            pc_next = pc + PC_ONE;
          end
        end
      end
      HALTED: begin
        if (Start) begin
          state_next   = RUN;
          pc_next      = StartAddr;
          start_accept = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = '0;
      end
    endcase
  end

  // Decoder-facing outputs. The instruction is passed through only while
  // running, so the decoder sees a zero opcode otherwise.
  always_comb begin
    ProgCtr    = pc;
    InstrValid = 1'b0;
    Done       = 1'b0;
    Instr      = '0;
    if (state == RUN) begin
      InstrValid = 1'b1;
      Instr      = InstrIn;
    end
    if (state == HALTED) begin
      Done = 1'b1;
    end
  end

  // Branch-target LUT. It can be written in any state and is cleared by reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < LUTD; i++) begin
        lut[i] <= '0;
      end
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] cycle_cnt;
  logic [15:0] instr_cnt;

  // Performance counters clear on the edge that accepts Start and then count
  // RUN cycles. A stalled cycle counts as a cycle but not as an instruction.
  // Both counters saturate instead of wrapping.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (start_accept) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (state == RUN) begin
      if (cycle_cnt != 16'hFFFF) begin
        cycle_cnt <= cycle_cnt + 16'd1;
      end
      if (!Stall && instr_cnt != 16'hFFFF) begin
        instr_cnt <= instr_cnt + 16'd1;
      end
    end
  end

  assign CycleCount = cycle_cnt;
  assign InstrCount = instr_cnt;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
  assign CycleCount = 16'd0;
  assign InstrCount = 16'd0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed self-checking bench for instr_fetch. Each task drives one scenario
// and compares the outputs with hand-computed values one time unit after the
// active clock edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [9:0]  StartAddr;
  logic        Stall;
  logic [9:0]  ProgCtr;
  logic [8:0]  InstrIn;
  logic [8:0]  Instr;
  logic        InstrValid;
  logic        Branch;
  logic        Halt;
  logic        Taken;
  logic        LutWe;
  logic [3:0]  LutAddr;
  logic [9:0]  LutData;
  logic        Done;
  logic [15:0] CycleCount;
  logic [15:0] InstrCount;

  int num_checks = 0;
  int num_fails  = 0;

  instr_fetch dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .Stall      (Stall),
    .ProgCtr    (ProgCtr),
    .InstrIn    (InstrIn),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .Branch     (Branch),
    .Halt       (Halt),
    .Taken      (Taken),
    .LutWe      (LutWe),
    .LutAddr    (LutAddr),
    .LutData    (LutData),
    .Done       (Done),
    .CycleCount (CycleCount),
    .InstrCount (InstrCount)
  );

  // 10-unit clock period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Wait for the next rising edge, then settle one unit past it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Start     = 1'b0;
    Stall     = 1'b0;
    Branch    = 1'b0;
    Halt      = 1'b0;
    Taken     = 1'b0;
    LutWe     = 1'b0;
    LutAddr   = 4'd0;
    LutData   = 10'd0;
    StartAddr = 10'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    InstrIn = 9'h1FF;
    Reset   = 1'b0;
    #12;
    num_checks++;
    if (ProgCtr !== 10'h000) begin
      num_fails++; $display("[TB] FAIL reset_pc got %h expected %h", ProgCtr, 10'h000);
    end
    num_checks++;
    if (InstrValid !== 1'b0 || Done !== 1'b0) begin
      num_fails++; $display("[TB] FAIL reset_flags got valid=%b done=%b expected 0/0", InstrValid, Done);
    end
    num_checks++;
    if (Instr !== 9'h000) begin
      num_fails++; $display("[TB] FAIL reset_instr got %h expected %h", Instr, 9'h000);
    end
    num_checks++;
    if (CycleCount !== 16'd0 || InstrCount !== 16'd0) begin
      num_fails++; $display("[TB] FAIL reset_counts got %0d/%0d expected 0/0", CycleCount, InstrCount);
    end
    Reset = 1'b1;
    step();
    num_checks++;
    if (ProgCtr !== 10'h000 || InstrValid !== 1'b0) begin
      num_fails++; $display("[TB] FAIL idle_hold got pc=%h valid=%b expected 000/0", ProgCtr, InstrValid);
    end
  endtask

  task automatic test_sequential();
    InstrIn   = 9'h00A;
    Start     = 1'b1;
    StartAddr = 10'h005;
    step();
    Start = 1'b0;
    num_checks++;
    if (ProgCtr !== 10'h005 || InstrValid !== 1'b1) begin
      num_fails++; $display("[TB] FAIL seq_start got pc=%h valid=%b expected 005/1", ProgCtr, InstrValid);
    end
    num_checks++;
    if (Instr !== 9'h00A) begin
      num_fails++; $display("[TB] FAIL seq_instr got %h expected %h", Instr, 9'h00A);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      num_checks++;
      if (ProgCtr !== 10'(10'h005 + i)) begin
        num_fails++; $display("[TB] FAIL seq_pc%0d got %h expected %h", i, ProgCtr, 10'(10'h005 + i));
      end
    end
`ifdef FETCH_PERF_EN
    num_checks++;
    if (CycleCount !== 16'd3 || InstrCount !== 16'd3) begin
      num_fails++; $display("[TB] FAIL seq_counts got %0d/%0d expected 3/3", CycleCount, InstrCount);
    end
`endif
  endtask

  task automatic test_branch();
    // At PC 0x008: program LUT[3]=0x040.
    LutWe = 1'b1; LutAddr = 4'd3; LutData = 10'h040;
    step();
    LutWe = 1'b0;
    // Now at PC 0x009: taken bne to index 3.
    InstrIn = 9'h063; Branch = 1'b1; Taken = 1'b1;
    step();
    num_checks++;
    if (ProgCtr !== 10'h040) begin
      num_fails++; $display("[TB] FAIL branch_taken got %h expected %h", ProgCtr, 10'h040);
    end
    Taken = 1'b0;
    step();
    num_checks++;
    if (ProgCtr !== 10'h041) begin
      num_fails++; $display("[TB] FAIL branch_not_taken got %h expected %h", ProgCtr, 10'h041);
    end
    Branch = 1'b0;
  endtask

  task automatic test_halt();
    InstrIn = 9'h000;
    Start = 1'b1; StartAddr = 10'h012;
    step();
    Start = 1'b0;
    num_checks++;
    if (ProgCtr !== 10'h012) begin
      num_fails++; $display("[TB] FAIL restart_pc got %h expected %h", ProgCtr, 10'h012);
    end
    Halt = 1'b1;
    step();
    num_checks++;
    if (ProgCtr !== 10'h012 || Done !== 1'b1 || InstrValid !== 1'b0) begin
      num_fails++; $display("[TB] FAIL halt_state got pc=%h done=%b valid=%b expected 012/1/0", ProgCtr, Done, InstrValid);
    end
    // Strobes are ignored while halted.
    Branch = 1'b1; Taken = 1'b1; InstrIn = 9'h063;
    step();
    num_checks++;
    if (ProgCtr !== 10'h012 || Done !== 1'b1 || Instr !== 9'h000) begin
      num_fails++; $display("[TB] FAIL halt_hold got pc=%h done=%b instr=%h expected 012/1/000", ProgCtr, Done, Instr);
    end
    Halt = 1'b0; Branch = 1'b0; Taken = 1'b0;
    Start = 1'b1; StartAddr = 10'h000;
    step();
    Start = 1'b0;
    num_checks++;
    if (ProgCtr !== 10'h000 || Done !== 1'b0 || InstrValid !== 1'b1) begin
      num_fails++; $display("[TB] FAIL halt_restart got pc=%h done=%b valid=%b expected 000/0/1", ProgCtr, Done, InstrValid);
    end
`ifdef FETCH_PERF_EN
    num_checks++;
    if (CycleCount !== 16'd0 || InstrCount !== 16'd0) begin
      num_fails++; $display("[TB] FAIL start_clears_counts got %0d/%0d expected 0/0", CycleCount, InstrCount);
    end
`endif
  endtask

  task automatic test_stall();
    InstrIn = 9'h000;
    Start = 1'b1; StartAddr = 10'h020;
    step();
    Start = 1'b0;
    Stall = 1'b1; Halt = 1'b1;
    step();
    step();
    num_checks++;
    if (ProgCtr !== 10'h020 || InstrValid !== 1'b1 || Done !== 1'b0) begin
      num_fails++; $display("[TB] FAIL stall_hold got pc=%h valid=%b done=%b expected 020/1/0", ProgCtr, InstrValid, Done);
    end
`ifdef FETCH_PERF_EN
    num_checks++;
    if (CycleCount !== 16'd2 || InstrCount !== 16'd0) begin
      num_fails++; $display("[TB] FAIL stall_counts got %0d/%0d expected 2/0", CycleCount, InstrCount);
    end
`endif
    Stall = 1'b0; Halt = 1'b0;
    step();
    num_checks++;
    if (ProgCtr !== 10'h021) begin
      num_fails++; $display("[TB] FAIL stall_release got %h expected %h", ProgCtr, 10'h021);
    end
  endtask

  task automatic test_wrap();
    Start = 1'b1; StartAddr = 10'h3FF;
    step();
    Start = 1'b0;
    step();
    num_checks++;
    if (ProgCtr !== 10'h000 || InstrValid !== 1'b1) begin
      num_fails++; $display("[TB] FAIL pc_wrap got pc=%h valid=%b expected 000/1", ProgCtr, InstrValid);
    end
  endtask

  task automatic test_lut_same_cycle();
    LutWe = 1'b1; LutAddr = 4'd5; LutData = 10'h080;
    step();
    // The write of 0x100 and the branch happen in the same cycle.
    LutData = 10'h100;
    InstrIn = 9'h065; Branch = 1'b1; Taken = 1'b1;
    step();
    LutWe = 1'b0;
    num_checks++;
    if (ProgCtr !== 10'h080) begin
      num_fails++; $display("[TB] FAIL lut_old_value got %h expected %h", ProgCtr, 10'h080);
    end
    step();
    num_checks++;
    if (ProgCtr !== 10'h100) begin
      num_fails++; $display("[TB] FAIL lut_new_value got %h expected %h", ProgCtr, 10'h100);
    end
    Branch = 1'b0; Taken = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    InstrIn = 9'h000;
    step();
    #2;
    Reset = 1'b0;
    #1;
    num_checks++;
    if (ProgCtr !== 10'h000 || InstrValid !== 1'b0) begin
      num_fails++; $display("[TB] FAIL async_reset got pc=%h valid=%b expected 000/0", ProgCtr, InstrValid);
    end
    #3;
    Reset = 1'b1;
    step();
    step();
    num_checks++;
    if (ProgCtr !== 10'h000 || InstrValid !== 1'b0 || Done !== 1'b0) begin
      num_fails++; $display("[TB] FAIL post_reset_idle got pc=%h valid=%b done=%b expected 000/0/0", ProgCtr, InstrValid, Done);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_stall();
    test_wrap();
    test_lut_same_cycle();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
